parent_tx_arbiter: RTL and testbench

PARENT_TX_ARBITER -- requirements
Module: parent_tx_arbiter

---
 rtl/parent_tx_arbiter.sv | 106 ++++++++++
 tb/tb_parent_tx_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/parent_tx_arbiter.sv
// parent_tx_arbiter: arbitrates NUM_REQ requester channels into one registered message stream toward the parent FPGA
//   clk, reset           : clock, synchronous active-high reset
//   req_data/req_valid   : per-requester message slices and valids
//   req_ready            : per-requester accept (one-hot or zero)
//   parent_tx_*          : registered output message, valid, source index; parent_tx_ready accepts it
//   link_quiet           : link idle for ROUTER_DELAY cycles
//   stall_count          : saturating count of back-pressured output cycles
module parent_tx_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int DATA_WIDTH   = 64,
    parameter int ROUTER_DELAY = 18,
    parameter int HIPRI_EN     = 1,
    localparam int SW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         parent_tx_data,
    output logic                          parent_tx_valid,
    input  logic                          parent_tx_ready,
    output logic [SW-1:0]                 parent_tx_src,
    output logic                          link_quiet,
    output logic [15:0]                   stall_count
);
    localparam int RR_BASE = (HIPRI_EN != 0) ? 1 : 0;
    localparam int RR_N    = NUM_REQ - RR_BASE;
    localparam int QW      = (ROUTER_DELAY > 0) ? $clog2(ROUTER_DELAY + 1) : 1;

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic [SW-1:0]         r_src;
    logic [SW-1:0]         r_last_rr;
    logic [15:0]           r_stall;
    logic [QW-1:0]         r_quiet;

    logic                  w_open;
    logic                  w_found;
    logic                  w_rr;
    logic                  w_xfer;
    logic [SW-1:0]         w_gidx;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // k-th candidate after last, wrapping inside the round-robin pool [RR_BASE, NUM_REQ-1]
    function automatic int rr_idx(input int last, input int k);
        return RR_BASE + ((last - RR_BASE + k) % RR_N);
    endfunction

    assign w_open = ~r_valid | parent_tx_ready;

    always_comb begin
        w_found = 1'b0;
        w_rr    = 1'b0;
        w_gidx  = '0;
        if (HIPRI_EN != 0 && req_valid[0]) begin
            w_found = 1'b1;
        end else begin
            for (int k = 1; k <= RR_N; k++) begin
                if (!w_found && |(req_valid & (NUM_REQ'(1) << rr_idx(int'(r_last_rr), k)))) begin
                    w_found = 1'b1;
                    w_rr    = 1'b1;
                    w_gidx  = SW'(rr_idx(int'(r_last_rr), k));
                end
            end
        end
    end

    assign w_xfer     = ~reset & w_open & w_found;
    assign req_ready  = w_xfer ? (NUM_REQ'(1) << w_gidx) : '0;
    assign w_sel_data = DATA_WIDTH'(req_data >> (int'(w_gidx) * DATA_WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_src     <= '0;
            r_last_rr <= SW'(NUM_REQ - 1);
            r_stall   <= '0;
            r_quiet   <= '0;
        end else begin
            if (w_xfer) begin
                r_valid <= 1'b1;
                r_data  <= w_sel_data;
                r_src   <= w_gidx;
            end else if (w_open) begin
                r_valid <= 1'b0;
            end
            // fixed-priority grants of requester 0 leave the round-robin pointer alone
            if (w_xfer && w_rr)
                r_last_rr <= w_gidx;
            if (r_valid && !parent_tx_ready && r_stall != 16'hFFFF)
                r_stall <= r_stall + 16'd1;
            if (|req_valid || r_valid)
                r_quiet <= '0;
            else if (r_quiet != QW'(ROUTER_DELAY))
                r_quiet <= r_quiet + 1'b1;
        end
    end

    assign parent_tx_data  = r_data;
    assign parent_tx_valid = r_valid;
    assign parent_tx_src   = r_src;
    assign stall_count     = r_stall;
    assign link_quiet      = (r_quiet == QW'(ROUTER_DELAY)) & ~r_valid & ~|req_valid;
endmodule

// File: tb/tb_parent_tx_arbiter.sv
// tb_parent_tx_arbiter: randomized scoreboard bench for parent_tx_arbiter against a behavioural model
module tb_parent_tx_arbiter;
    localparam int NR = 3;
    localparam int DW = 64;
    localparam int RD = 18;
    localparam int HP = 1;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [DW-1:0]     parent_tx_data;
    logic              parent_tx_valid;
    logic              parent_tx_ready = 1'b0;
    logic [SW-1:0]     parent_tx_src;
    logic              link_quiet;
    logic [15:0]       stall_count;

    parent_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ROUTER_DELAY(RD), .HIPRI_EN(HP)) dut (
        .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
        .parent_tx_data(parent_tx_data), .parent_tx_valid(parent_tx_valid), .parent_tx_ready(parent_tx_ready),
        .parent_tx_src(parent_tx_src), .link_quiet(link_quiet), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          exp_q[$];
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] d[NR];
    logic [DW-1:0] fix1 = '0;
    bit            use_fix = 0;

    // behavioural model state
    bit            m_valid = 0;
    logic [DW-1:0] m_data = '0;
    int            m_src = 0;
    int            m_last = NR - 1;
    int            m_stall = 0;
    int            idle_run = 0;
    bit            in_rst = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: every output transfer must match the oldest accepted message
    always @(negedge clk) begin
        if (!reset && parent_tx_valid === 1'b1 && parent_tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected: got src=%0d data=%h expected no transfer", parent_tx_src, parent_tx_data);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                if (parent_tx_src !== SW'(e.src) || parent_tx_data !== e.data) begin
                    failures++;
                    $display("FAIL out_msg: got src=%0d data=%h expected src=%0d data=%h",
                             parent_tx_src, parent_tx_data, e.src, e.data);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic [NR-1:0] v, input logic rdy);
        bit   open, rr, idle, old_valid;
        int   g, c;
        logic [NR-1:0] exp_rdy;
        reset = rst;
        req_valid = v;
        parent_tx_ready = rdy;
        for (int i = 0; i < NR; i++) begin
            d[i] = {$urandom, $urandom};
            if (i == 1 && use_fix) d[i] = fix1;
            req_data[i*DW +: DW] = d[i];
        end
        @(negedge clk);
        #1;
        if (rst) begin
            chk("req_ready_rst", 64'(req_ready), 64'd0);
            if (in_rst) begin
                chk("valid_rst", 64'(parent_tx_valid), 64'd0);
                chk("data_rst", parent_tx_data, 64'd0);
                chk("src_rst", 64'(parent_tx_src), 64'd0);
                chk("stall_rst", 64'(stall_count), 64'd0);
                chk("quiet_rst", 64'(link_quiet), 64'd0);
            end
            m_valid = 0; m_data = '0; m_src = 0; m_last = NR - 1; m_stall = 0; idle_run = 0;
            exp_q.delete();
            in_rst = 1;
        end else begin
            in_rst = 0;
            open = !m_valid || rdy;
            g = -1;
            rr = 0;
            if (HP != 0 && v[0]) begin
                g = 0;
            end else begin
                c = m_last;
                for (int k = 0; k < NR; k++) begin
                    c = c + 1;
                    if (c >= NR) c = (HP != 0) ? 1 : 0;
                    if (g < 0 && v[c]) begin
                        g = c;
                        rr = 1;
                    end
                end
            end
            exp_rdy = (g >= 0 && open) ? (NR'(1) << g) : '0;
            idle = (v == 0) && !m_valid;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("tx_valid", 64'(parent_tx_valid), 64'(m_valid));
            if (m_valid) begin
                chk("tx_data", parent_tx_data, m_data);
                chk("tx_src", 64'(parent_tx_src), 64'(m_src));
            end
            chk("stall_count", 64'(stall_count), 64'(m_stall));
            chk("link_quiet", 64'(link_quiet), 64'(idle && idle_run >= RD));
            old_valid = m_valid;
            if (g >= 0 && open) begin
                exp_q.push_back('{src: g, data: d[g]});
                m_valid = 1;
                m_data = d[g];
                m_src = g;
                if (rr) m_last = g;
            end else if (open) begin
                m_valid = 0;
            end
            if (old_valid && !rdy && m_stall < 65535) m_stall++;
            idle_run = idle ? ((idle_run < RD) ? idle_run + 1 : idle_run) : 0;
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        @(posedge clk);
        #2;
        repeat (2) step(1, 3'b000, 1'b0);
        repeat (6) step(0, 3'b011, 1'b1);
        repeat (6) step(0, 3'b110, 1'b1);
        repeat (2) step(0, 3'b000, 1'b1);
        fix1 = 64'hDEAD_BEEF_0000_0001;
        use_fix = 1;
        step(0, 3'b010, 1'b1);
        use_fix = 0;
        repeat (5) step(0, 3'b100, 1'b0);
        step(0, 3'b100, 1'b1);
        repeat (25) step(0, 3'b000, 1'b1);
        step(0, 3'b001, 1'b1);
        repeat (25) step(0, 3'b000, 1'b1);
        repeat (3000) step(0, NR'($urandom), $urandom_range(0, 3) != 0);
        step(0, 3'b010, 1'b1);
        step(1, 3'b110, 1'b1);
        repeat (4) step(0, 3'b110, 1'b1);
        repeat (2) step(0, 3'b000, 1'b1);
        step(0, 3'b001, 1'b1);
        repeat (70000) step(0, 3'b000, 1'b0);
        repeat (3) step(0, 3'b000, 1'b1);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
